// File: rtl/mem_stage_if.sv
// Data-memory port between mem_stage (master) and the memory system (slave).
// Request is valid/ready; exactly one response or write acknowledgement follows each accepted request.
interface mem_stage_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic        resp_valid;
    logic [63:0] rdata;

    modport master (
        output req_valid, addr, wen, wdata, wmask,
        input  req_ready, resp_valid, rdata
    );

    modport slave (
        input  req_valid, addr, wen, wdata, wmask,
        output req_ready, resp_valid, rdata
    );
endinterface

// File: rtl/mem_stage.sv
// rv64IM memory stage: ALU/misaligned ops retire 1 cycle after acceptance, loads/stores >= 3 cycles.
// ready_o is low while a bus transaction is outstanding; request fields stay frozen until the handshake.
module mem_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [63:0] aluout_i,
    input  logic [3:0]  memop_i,
    input  logic [63:0] store_data_i,
    input  logic [4:0]  rf_rd_i,
    input  logic        rf_wen_i,
    input  logic [63:0] pc_i,
    input  logic        exit_i,
    mem_stage_if.master dmem,
    output logic        wb_valid_o,
    output logic [4:0]  rf_rd_o,
    output logic        rf_wen_o,
    output logic [63:0] rf_wdata_o,
    output logic [63:0] pc_o,
    output logic        exit_o,
    output logic        misalign_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [3:0]  memop_q, memop_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wmask_q, wmask_d;
    logic [4:0]  rd_q, rd_d;
    logic        rfwen_q, rfwen_d;
    logic [63:0] pc_q, pc_d;
    logic        exit_q, exit_d;

    logic        wb_vld_q, wb_vld_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_wen_q, wb_wen_d;
    logic [63:0] wb_wdata_q, wb_wdata_d;
    logic [63:0] wb_pc_q, wb_pc_d;
    logic        wb_exit_q, wb_exit_d;
    logic        wb_mis_q, wb_mis_d;

    logic        is_load, is_store, misal;
    logic [1:0]  size_log2;
    logic [7:0]  size_mask;
    logic [63:0] rd_shifted, load_val;

    always_comb begin
        is_load  = memop_i inside {[4'd1:4'd7]};
        is_store = memop_i inside {[4'd8:4'd11]};
        case (memop_i)
            4'd1, 4'd5, 4'd8:  size_log2 = 2'd0;
            4'd2, 4'd6, 4'd9:  size_log2 = 2'd1;
            4'd3, 4'd7, 4'd10: size_log2 = 2'd2;
            default:           size_log2 = 2'd3;
        endcase
        case (size_log2)
            2'd0:    begin size_mask = 8'h01; misal = 1'b0;            end
            2'd1:    begin size_mask = 8'h03; misal = aluout_i[0];     end
            2'd2:    begin size_mask = 8'h0F; misal = |aluout_i[1:0];  end
            default: begin size_mask = 8'hFF; misal = |aluout_i[2:0];  end
        endcase
        misal = misal & (is_load | is_store);
    end

    // Bus returns the whole doubleword; move the addressed bytes down to bit 0 before extension.
    always_comb begin
        rd_shifted = dmem.rdata >> {addr_q[2:0], 3'b000};
        case (memop_q)
            4'd1:    load_val = {{56{rd_shifted[7]}},  rd_shifted[7:0]};
            4'd2:    load_val = {{48{rd_shifted[15]}}, rd_shifted[15:0]};
            4'd3:    load_val = {{32{rd_shifted[31]}}, rd_shifted[31:0]};
            4'd5:    load_val = {56'd0, rd_shifted[7:0]};
            4'd6:    load_val = {48'd0, rd_shifted[15:0]};
            4'd7:    load_val = {32'd0, rd_shifted[31:0]};
            default: load_val = rd_shifted;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        memop_d    = memop_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        rd_d       = rd_q;
        rfwen_d    = rfwen_q;
        pc_d       = pc_q;
        exit_d     = exit_q;
        wb_vld_d   = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_wen_d   = wb_wen_q;
        wb_wdata_d = wb_wdata_q;
        wb_pc_d    = wb_pc_q;
        wb_exit_d  = wb_exit_q;
        wb_mis_d   = wb_mis_q;
        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    if (!is_load && !is_store) begin
                        wb_vld_d   = 1'b1;
                        wb_rd_d    = rf_rd_i;
                        wb_wen_d   = rf_wen_i && (rf_rd_i != 5'd0);
                        wb_wdata_d = aluout_i;
                        wb_pc_d    = pc_i;
                        wb_exit_d  = exit_i;
                        wb_mis_d   = 1'b0;
                    end else if (misal) begin
                        wb_vld_d   = 1'b1;
                        wb_rd_d    = rf_rd_i;
                        wb_wen_d   = 1'b0;
                        wb_wdata_d = aluout_i;
                        wb_pc_d    = pc_i;
                        wb_exit_d  = exit_i;
                        wb_mis_d   = 1'b1;
                    end else begin
                        addr_d  = aluout_i;
                        memop_d = memop_i;
                        wdata_d = is_store ? (store_data_i << {aluout_i[2:0], 3'b000}) : 64'd0;
                        wmask_d = is_store ? (size_mask << aluout_i[2:0]) : 8'd0;
                        rd_d    = rf_rd_i;
                        rfwen_d = rf_wen_i && (rf_rd_i != 5'd0) && !is_store;
                        pc_d    = pc_i;
                        exit_d  = exit_i;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (dmem.req_ready) state_d = S_RESP;
            end
            S_RESP: begin
                if (dmem.resp_valid) begin
                    wb_vld_d   = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_wen_d   = rfwen_q;
                    wb_wdata_d = memop_q[3] ? addr_q : load_val;
                    wb_pc_d    = pc_q;
                    wb_exit_d  = exit_q;
                    wb_mis_d   = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= 64'd0;
            memop_q    <= 4'd0;
            wdata_q    <= 64'd0;
            wmask_q    <= 8'd0;
            rd_q       <= 5'd0;
            rfwen_q    <= 1'b0;
            pc_q       <= 64'd0;
            exit_q     <= 1'b0;
            wb_vld_q   <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_wen_q   <= 1'b0;
            wb_wdata_q <= 64'd0;
            wb_pc_q    <= 64'd0;
            wb_exit_q  <= 1'b0;
            wb_mis_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            memop_q    <= memop_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            rd_q       <= rd_d;
            rfwen_q    <= rfwen_d;
            pc_q       <= pc_d;
            exit_q     <= exit_d;
            wb_vld_q   <= wb_vld_d;
            wb_rd_q    <= wb_rd_d;
            wb_wen_q   <= wb_wen_d;
            wb_wdata_q <= wb_wdata_d;
            wb_pc_q    <= wb_pc_d;
            wb_exit_q  <= wb_exit_d;
            wb_mis_q   <= wb_mis_d;
        end
    end

    assign ready_o        = (state_q == S_IDLE);
    assign dmem.req_valid = (state_q == S_REQ);
    assign dmem.addr      = {addr_q[63:3], 3'b000};
    assign dmem.wen       = memop_q[3];
    assign dmem.wdata     = wdata_q;
    assign dmem.wmask     = wmask_q;

    assign wb_valid_o = wb_vld_q;
    assign rf_rd_o    = wb_rd_q;
    assign rf_wen_o   = wb_wen_q;
    assign rf_wdata_o = wb_wdata_q;
    assign pc_o       = wb_pc_q;
    assign exit_o     = wb_exit_q;
    assign misalign_o = wb_mis_q;
endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: byte-level reference model, scripted memory responder, writeback scoreboard.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, ready_o;
    logic [63:0] aluout_i, store_data_i, pc_i;
    logic [3:0]  memop_i;
    logic [4:0]  rf_rd_i;
    logic        rf_wen_i, exit_i;
    logic        wb_valid_o, rf_wen_o, exit_o, misalign_o;
    logic [4:0]  rf_rd_o;
    logic [63:0] rf_wdata_o, pc_o;

    mem_stage_if dmem();

    mem_stage dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .aluout_i(aluout_i), .memop_i(memop_i), .store_data_i(store_data_i),
        .rf_rd_i(rf_rd_i), .rf_wen_i(rf_wen_i), .pc_i(pc_i), .exit_i(exit_i),
        .dmem(dmem),
        .wb_valid_o(wb_valid_o), .rf_rd_o(rf_rd_o), .rf_wen_o(rf_wen_o),
        .rf_wdata_o(rf_wdata_o), .pc_o(pc_o), .exit_o(exit_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic        wen;
        logic [63:0] wdata;
        bit          chk_wdata;
        logic [63:0] pc;
        logic        ex;
        logic        mis;
    } wb_t;

    typedef struct {
        logic [63:0] addr;
        logic        wen;
        logic [7:0]  wmask;
        logic [63:0] wdata;
        logic [63:0] rdata;
    } rq_t;

    wb_t  wb_q[$];
    rq_t  rq_q[$];
    int   n_chk = 0, n_pass = 0;
    int   req_dly = -1, resp_dly = -1;
    bit   mem_auto = 1'b1;
    logic [4:0] last_rd = 5'd0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference: byte-granular view of the access.
    task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] sd,
                        input logic [4:0] rd, input logic wen, input logic [63:0] rdata);
        wb_t w;
        rq_t r;
        bit ld, st, mis, sgn;
        int n, off, cnt;
        logic [63:0] v, pc;
        logic ex;
        ld  = (op >= 1) && (op <= 7);
        st  = (op >= 8) && (op <= 11);
        sgn = (op >= 1) && (op <= 3);
        case (op)
            4'd1, 4'd5, 4'd8:  n = 1;
            4'd2, 4'd6, 4'd9:  n = 2;
            4'd3, 4'd7, 4'd10: n = 4;
            default:           n = 8;
        endcase
        off = int'(a % 64'd8);
        mis = (ld || st) && ((a % 64'(n)) != 64'd0);
        v = 64'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = rdata[8*(off+i) +: 8];
        if (sgn && n < 8 && v[8*n-1]) for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
        pc = {$urandom, $urandom};
        ex = 1'($urandom_range(0, 1));

        w.rd = rd; w.pc = pc; w.ex = ex; w.mis = mis;
        w.wen = wen && (rd != 5'd0) && !st && !mis;
        w.chk_wdata = !st && !mis;
        w.wdata = ld ? v : a;
        r.addr = a - (a % 64'd8);
        r.wen = st;
        r.wmask = 8'd0;
        for (int i = 0; i < n; i++) r.wmask[off+i] = 1'b1;
        r.wdata = sd << (8 * off);
        r.rdata = rdata;

        valid_i = 1'b1; memop_i = op; aluout_i = a; store_data_i = sd;
        rf_rd_i = rd; rf_wen_i = wen; pc_i = pc; exit_i = ex;
        cnt = 0;
        while (!ready_o && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        if (!ready_o) begin
            check("accept_timeout", 64'(ready_o), 64'd1);
            valid_i = 1'b0;
            return;
        end
        wb_q.push_back(w);
        if ((ld || st) && !mis) rq_q.push_back(r);
        @(negedge clk);
        valid_i = 1'b0;
        if (!(ld || st) || mis) check("wb_latency_1", 64'(wb_valid_o), 64'd1);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready_o && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!ready_o) check("ready_timeout", 64'(ready_o), 64'd1);
    endtask

    task automatic drain();
        int cnt;
        cnt = 0;
        while (!(ready_o && rq_q.size() == 0 && wb_q.size() == 0) && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        check("drain_pending", 64'(wb_q.size() + rq_q.size()), 64'd0);
    endtask

    // Writeback scoreboard.
    initial begin
        wb_t w;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (wb_valid_o) begin
                    if (wb_q.size() == 0) check("spurious_wb", 64'd1, 64'd0);
                    else begin
                        w = wb_q.pop_front();
                        check("wb_rd", 64'(rf_rd_o), 64'(w.rd));
                        check("wb_wen", 64'(rf_wen_o), 64'(w.wen));
                        check("wb_mis", 64'(misalign_o), 64'(w.mis));
                        check("wb_pc", pc_o, w.pc);
                        check("wb_exit", 64'(exit_o), 64'(w.ex));
                        if (w.chk_wdata) check("wb_wdata", rf_wdata_o, w.wdata);
                        last_rd = w.rd;
                    end
                end else begin
                    check("wb_rd_hold", 64'(rf_rd_o), 64'(last_rd));
                end
            end
        end
    end

    // Memory responder with programmable or random stall lengths.
    initial begin
        rq_t r;
        int d;
        dmem.req_ready = 1'b0; dmem.resp_valid = 1'b0; dmem.rdata = 64'd0;
        forever begin
            @(negedge clk);
            if (mem_auto && rst_n && dmem.req_valid) begin
                if (rq_q.size() == 0) check("spurious_req", 64'd1, 64'd0);
                else begin
                    r = rq_q[0];
                    d = (req_dly >= 0) ? req_dly : $urandom_range(0, 3);
                    for (int i = 0; i <= d; i++) begin
                        if (i > 0) @(negedge clk);
                        check("req_vld_held", 64'(dmem.req_valid), 64'd1);
                        check("req_addr", dmem.addr, r.addr);
                        check("req_wen", 64'(dmem.wen), 64'(r.wen));
                        if (r.wen) begin
                            check("req_wmask", 64'(dmem.wmask), 64'(r.wmask));
                            check("req_wdata", dmem.wdata, r.wdata);
                        end
                    end
                    dmem.req_ready = 1'b1;
                    @(negedge clk);
                    dmem.req_ready = 1'b0;
                    void'(rq_q.pop_front());
                    check("req_dropped", 64'(dmem.req_valid), 64'd0);
                    d = (resp_dly >= 0) ? resp_dly : $urandom_range(0, 3);
                    repeat (d) begin
                        check("resp_wait_stall", 64'(ready_o), 64'd0);
                        @(negedge clk);
                    end
                    dmem.resp_valid = 1'b1;
                    dmem.rdata = r.rdata;
                    @(negedge clk);
                    dmem.resp_valid = 1'b0;
                    dmem.rdata = {$urandom, $urandom};
                end
            end
        end
    end

    initial begin
        int n;
        logic [63:0] a;
        rst_n = 1'b0; valid_i = 1'b0; memop_i = 4'd0; aluout_i = 64'd0; store_data_i = 64'd0;
        rf_rd_i = 5'd0; rf_wen_i = 1'b0; pc_i = 64'd0; exit_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(ready_o), 64'd1);
        check("rst_wb_valid", 64'(wb_valid_o), 64'd0);
        check("rst_req_valid", 64'(dmem.req_valid), 64'd0);
        check("rst_misalign", 64'(misalign_o), 64'd0);
        check("rst_rf_wen", 64'(rf_wen_o), 64'd0);
        check("rst_wdata", rf_wdata_o, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        req_dly = 0; resp_dly = 0;
        send(4'd0, 64'h1234, 64'd0, 5'd5, 1'b1, 64'd0);
        check("alu_wdata", rf_wdata_o, 64'h1234);
        check("alu_wen", 64'(rf_wen_o), 64'd1);
        check("alu_ready", 64'(ready_o), 64'd1);

        send(4'd1, 64'h1003, 64'd0, 5'd6, 1'b1, 64'h0000_0000_8000_0000);
        wait_ready(n);
        check("lb_stall_cycles", 64'(n), 64'd2);
        check("lb_wb_valid", 64'(wb_valid_o), 64'd1);
        check("lb_wdata", rf_wdata_o, 64'hFFFF_FFFF_FFFF_FF80);

        send(4'd5, 64'h1003, 64'd0, 5'd6, 1'b1, 64'h0000_0000_8000_0000);
        wait_ready(n);
        check("lbu_wdata", rf_wdata_o, 64'h80);

        req_dly = 3; resp_dly = -1;
        send(4'd9, 64'h2006, 64'hABCD, 5'd3, 1'b1, 64'd0);
        wait_ready(n);
        check("sh_wen", 64'(rf_wen_o), 64'd0);
        req_dly = -1;

        send(4'd3, 64'h3002, 64'd0, 5'd4, 1'b1, 64'd0);
        check("lw_misalign", 64'(misalign_o), 64'd1);
        check("lw_mis_wen", 64'(rf_wen_o), 64'd0);
        check("lw_mis_noreq", 64'(dmem.req_valid), 64'd0);

        send(4'd4, 64'h5008, 64'd0, 5'd0, 1'b1, 64'h1122_3344_5566_7788);
        wait_ready(n);
        check("ld_rd0_wen", 64'(rf_wen_o), 64'd0);
        drain();

        // Reset while waiting for the response: the late response must not retire anything.
        mem_auto = 1'b0;
        send(4'd4, 64'h4000, 64'd0, 5'd7, 1'b1, 64'd0);
        check("rst_txn_req", 64'(dmem.req_valid), 64'd1);
        dmem.req_ready = 1'b1;
        @(negedge clk);
        dmem.req_ready = 1'b0;
        check("rst_txn_in_resp", 64'(ready_o), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ready", 64'(ready_o), 64'd1);
        check("midrst_req_valid", 64'(dmem.req_valid), 64'd0);
        check("midrst_wb_valid", 64'(wb_valid_o), 64'd0);
        check("midrst_rf_rd", 64'(rf_rd_o), 64'd0);
        wb_q.delete(); rq_q.delete(); last_rd = 5'd0;
        @(negedge clk);
        rst_n = 1'b1;
        dmem.resp_valid = 1'b1; dmem.rdata = 64'hDEAD_BEEF;
        @(negedge clk);
        dmem.resp_valid = 1'b0;
        repeat (3) begin
            check("late_resp_no_wb", 64'(wb_valid_o), 64'd0);
            @(negedge clk);
        end
        mem_auto = 1'b1;

        for (int i = 0; i < 6; i++)
            send(4'd0, {$urandom, $urandom}, 64'd0, 5'($urandom_range(0, 31)), 1'b1, 64'd0);

        for (int i = 0; i < 300; i++) begin
            a = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) a[2:0] = 3'd0;
            send(4'($urandom_range(0, 15)), a, {$urandom, $urandom},
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
